// File: rtl/ltssm_substate_sequencer_if.sv
// Purpose : handshake bundle between the LTSSM sequencer and the master RX/TX sub-LTSSMs.
// Latency : none (wires only).
// Backpressure: none; finish pulses are single-cycle and the sequencer latches them.
// Signals : trainEnable, rxFinish/rxExitTo, txFinish/txExitTo, recoveryReq (toward sequencer);
//           substate, substateStrobe, linkUp, linkFailed, watchdogPulse, mismatchPulse,
//           failCount (from sequencer).
interface ltssm_substate_sequencer_if;
    logic       trainEnable;
    logic       rxFinish;
    logic [4:0] rxExitTo;
    logic       txFinish;
    logic [4:0] txExitTo;
    logic       recoveryReq;
    logic [4:0] substate;
    logic       substateStrobe;
    logic       linkUp;
    logic       linkFailed;
    logic       watchdogPulse;
    logic       mismatchPulse;
    logic [2:0] failCount;

    // Sequencer side.
    modport master (
        input  trainEnable, rxFinish, rxExitTo, txFinish, txExitTo, recoveryReq,
        output substate, substateStrobe, linkUp, linkFailed, watchdogPulse,
               mismatchPulse, failCount
    );

    // Sub-LTSSM / link-control side.
    modport slave (
        output trainEnable, rxFinish, rxExitTo, txFinish, txExitTo, recoveryReq,
        input  substate, substateStrobe, linkUp, linkFailed, watchdogPulse,
               mismatchPulse, failCount
    );
endinterface

// File: rtl/ltssm_substate_sequencer.sv
// Purpose : top-level LTSSM sequencer; issues a substate request, waits for RX and TX
//           sub-LTSSM finish, reconciles their exit substates, bounds a stuck handshake
//           with a watchdog and tracks consecutive training failures.
// Latency : finish of the second side -> new substate 2 cycles -> next strobe 3 cycles.
// Backpressure: none; the sequencer simply waits in WAIT until both sides finish,
//           the watchdog fires (outside L0) or recovery is requested (in L0).
// Ports   : clk, reset (async active-low), lnk (master modport of the sequencer interface).
module ltssm_substate_sequencer #(
    parameter int WATCHDOG_CYCLES = 200000,
    parameter int MAX_RETRIES     = 4,
    parameter int CNT_W           = 18
) (
    input  logic                          clk,
    input  logic                          reset,
    ltssm_substate_sequencer_if.master    lnk
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [4:0]       SUB_DETECT_QUIET = 5'd0;
    localparam logic [4:0]       SUB_L0           = 5'd10;
    localparam logic [4:0]       SUB_RCV_LOCK     = 5'd11;
    localparam logic [CNT_W-1:0] WD_LAST          = CNT_W'(WATCHDOG_CYCLES - 1);
    localparam logic [2:0]       FAIL_LIMIT       = 3'(MAX_RETRIES);

    state_t           state, state_n;
    logic [4:0]       substate_q, substate_n;
    logic             strobe_q, strobe_n;
    logic             link_up_q, link_up_n;
    logic             link_failed_q, link_failed_n;
    logic             wd_pulse_q, wd_pulse_n;
    logic             mm_pulse_q, mm_pulse_n;
    logic [2:0]       fail_q, fail_n;
    logic             rx_done, rx_done_n;
    logic             tx_done, tx_done_n;
    logic [4:0]       rx_exit, rx_exit_n;
    logic [4:0]       tx_exit, tx_exit_n;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_n;
    logic             go_adv;
    logic [4:0]       next_sub;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            substate_q    <= SUB_DETECT_QUIET;
            strobe_q      <= 1'b0;
            link_up_q     <= 1'b0;
            link_failed_q <= 1'b0;
            wd_pulse_q    <= 1'b0;
            mm_pulse_q    <= 1'b0;
            fail_q        <= 3'd0;
            rx_done       <= 1'b0;
            tx_done       <= 1'b0;
            rx_exit       <= 5'd0;
            tx_exit       <= 5'd0;
            wd_cnt        <= '0;
        end else begin
            state         <= state_n;
            substate_q    <= substate_n;
            strobe_q      <= strobe_n;
            link_up_q     <= link_up_n;
            link_failed_q <= link_failed_n;
            wd_pulse_q    <= wd_pulse_n;
            mm_pulse_q    <= mm_pulse_n;
            fail_q        <= fail_n;
            rx_done       <= rx_done_n;
            tx_done       <= tx_done_n;
            rx_exit       <= rx_exit_n;
            tx_exit       <= tx_exit_n;
            wd_cnt        <= wd_cnt_n;
        end
    end

    // All outputs are registered: the next-state logic computes the value each output
    // takes in the state being entered, so strobe/pulses are glitch-free and reset to 0.
    always_comb begin
        state_n       = state;
        substate_n    = substate_q;
        strobe_n      = 1'b0;
        link_up_n     = link_up_q;
        link_failed_n = link_failed_q;
        wd_pulse_n    = 1'b0;
        mm_pulse_n    = 1'b0;
        fail_n        = fail_q;
        rx_done_n     = rx_done;
        tx_done_n     = tx_done;
        rx_exit_n     = rx_exit;
        tx_exit_n     = tx_exit;
        wd_cnt_n      = wd_cnt;
        go_adv        = 1'b0;
        next_sub      = SUB_DETECT_QUIET;

        case (state)
            S_IDLE: begin
                if (lnk.trainEnable) begin
                    state_n  = S_ISSUE;
                    strobe_n = 1'b1;
                end
            end

            S_ISSUE: begin
                if (!lnk.trainEnable) begin
                    state_n    = S_IDLE;
                    substate_n = SUB_DETECT_QUIET;
                    link_up_n  = 1'b0;
                    rx_done_n  = 1'b0;
                    tx_done_n  = 1'b0;
                end else begin
                    state_n   = S_WAIT;
                    rx_done_n = 1'b0;
                    tx_done_n = 1'b0;
                    wd_cnt_n  = '0;
                end
            end

            S_WAIT: begin
                if (!lnk.trainEnable) begin
                    state_n    = S_IDLE;
                    substate_n = SUB_DETECT_QUIET;
                    link_up_n  = 1'b0;
                    rx_done_n  = 1'b0;
                    tx_done_n  = 1'b0;
                end else begin
                    // First finish per side wins; later pulses are dropped.
                    if (lnk.rxFinish && !rx_done) begin
                        rx_done_n = 1'b1;
                        rx_exit_n = lnk.rxExitTo;
                    end
                    if (lnk.txFinish && !tx_done) begin
                        tx_done_n = 1'b1;
                        tx_exit_n = lnk.txExitTo;
                    end

                    // Priority: recovery (L0 only) > resolve > watchdog (outside L0).
                    if (substate_q == SUB_L0 && lnk.recoveryReq) begin
                        go_adv   = 1'b1;
                        next_sub = SUB_RCV_LOCK;
                    end else if (rx_done && tx_done) begin
                        go_adv = 1'b1;
                        if (rx_exit == tx_exit) begin
                            next_sub = rx_exit;
                        end else begin
                            next_sub   = SUB_DETECT_QUIET;
                            mm_pulse_n = 1'b1;
                        end
                    end else if (substate_q != SUB_L0) begin
                        if (wd_cnt == WD_LAST) begin
                            go_adv     = 1'b1;
                            next_sub   = SUB_DETECT_QUIET;
                            wd_pulse_n = 1'b1;
                        end else begin
                            wd_cnt_n = wd_cnt + 1'b1;
                        end
                    end

                    if (go_adv) begin
                        state_n    = S_ADVANCE;
                        substate_n = next_sub;
                        link_up_n  = (next_sub == SUB_L0);
                        // Only a fall back to detectQuiet from elsewhere counts as a failure.
                        if (next_sub == SUB_DETECT_QUIET && substate_q != SUB_DETECT_QUIET) begin
                            fail_n = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;
                        end else if (next_sub == SUB_L0) begin
                            fail_n = 3'd0;
                        end
                    end
                end
            end

            S_ADVANCE: begin
                if (fail_q >= FAIL_LIMIT) begin
                    state_n       = S_HALT;
                    link_failed_n = 1'b1;
                    substate_n    = SUB_DETECT_QUIET;
                    link_up_n     = 1'b0;
                end else if (lnk.trainEnable) begin
                    state_n  = S_ISSUE;
                    strobe_n = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end

            S_HALT: begin
                // Sticky until software drops trainEnable.
                if (!lnk.trainEnable) begin
                    state_n       = S_IDLE;
                    fail_n        = 3'd0;
                    link_failed_n = 1'b0;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign lnk.substate       = substate_q;
    assign lnk.substateStrobe = strobe_q;
    assign lnk.linkUp         = link_up_q;
    assign lnk.linkFailed     = link_failed_q;
    assign lnk.watchdogPulse  = wd_pulse_q;
    assign lnk.mismatchPulse  = mm_pulse_q;
    assign lnk.failCount      = fail_q;

endmodule

// File: tb/tb_ltssm_substate_sequencer.sv
// Purpose : self-checking bench for ltssm_substate_sequencer (table vectors + scoreboard
//           popped on each request strobe, plus hand sequences for latency, watchdog,
//           HALT, L0 recovery and mid-WAIT async reset).
`timescale 1ns/1ps
module tb_ltssm_substate_sequencer;

    localparam int WD   = 32;
    localparam int MAXR = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ltssm_substate_sequencer_if lnk();

    ltssm_substate_sequencer #(
        .WATCHDOG_CYCLES(WD),
        .MAX_RETRIES    (MAXR),
        .CNT_W          (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .lnk  (lnk.master)
    );

    typedef struct {
        logic [4:0] sub;
        logic [2:0] fail;
        logic       lu;
        logic       mm;
        logic       wd;
    } exp_t;

    typedef struct {
        logic [4:0] rx_exit;
        logic [4:0] tx_exit;
        int         rx_dly;
        int         tx_dly;
        logic [4:0] rx_dup;
        int         dup_dly;
        exp_t       exp;
    } vec_t;

    exp_t sb[$];
    vec_t vt[9];

    int   n_cmp   = 0;
    int   n_err   = 0;
    logic mm_seen = 1'b0;
    logic wd_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string name);
        int k;
        k = 0;
        while (lnk.substateStrobe !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check(name, lnk.substateStrobe, 1);
    endtask

    // Scoreboard: every request strobe closes out the previous advance.
    always @(posedge clk) begin
        #1;
        if (lnk.mismatchPulse === 1'b1) mm_seen = 1'b1;
        if (lnk.watchdogPulse === 1'b1) wd_seen = 1'b1;
        if (lnk.substateStrobe === 1'b1) begin
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_substate", lnk.substate,  e.sub);
                check("sb_failcnt",  lnk.failCount, e.fail);
                check("sb_linkup",   lnk.linkUp,    e.lu);
                check("sb_mismatch", mm_seen,       e.mm);
                check("sb_watchdog", wd_seen,       e.wd);
            end
            mm_seen = 1'b0;
            wd_seen = 1'b0;
        end
    end

    task automatic apply_vec(input vec_t v);
        int last;
        wait_strobe("vec_strobe");
        tick();
        sb.push_back(v.exp);
        last = (v.rx_dly > v.tx_dly) ? v.rx_dly : v.tx_dly;
        if (v.dup_dly > last) last = v.dup_dly;
        for (int c = 0; c <= last; c++) begin
            lnk.rxFinish = (c == v.rx_dly) || (c == v.dup_dly);
            lnk.rxExitTo = (c == v.dup_dly) ? v.rx_dup : ((c == v.rx_dly) ? v.rx_exit : 5'd31);
            lnk.txFinish = (c == v.tx_dly);
            lnk.txExitTo = (c == v.tx_dly) ? v.tx_exit : 5'd31;
            tick();
        end
        lnk.rxFinish = 1'b0;
        lnk.txFinish = 1'b0;
    endtask

    task automatic both_finish(input logic [4:0] ex);
        lnk.rxFinish = 1'b1; lnk.rxExitTo = ex;
        lnk.txFinish = 1'b1; lnk.txExitTo = ex;
        tick();
        lnk.rxFinish = 1'b0;
        lnk.txFinish = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;

        // Table starts from substate 1, failCount 0.
        vt[0] = '{5'd2,  5'd2,  0, 4, 5'd9, 1,  '{5'd2,  3'd0, 1'b0, 1'b0, 1'b0}};
        vt[1] = '{5'd5,  5'd5,  0, 7, 5'd0, -1, '{5'd5,  3'd0, 1'b0, 1'b0, 1'b0}};
        vt[2] = '{5'd5,  5'd0,  0, 0, 5'd0, -1, '{5'd0,  3'd1, 1'b0, 1'b1, 1'b0}};
        vt[3] = '{5'd0,  5'd0,  0, 0, 5'd0, -1, '{5'd0,  3'd1, 1'b0, 1'b0, 1'b0}};
        vt[4] = '{5'd3,  5'd3,  2, 0, 5'd0, -1, '{5'd3,  3'd1, 1'b0, 1'b0, 1'b0}};
        vt[5] = '{5'd7,  5'd9,  1, 1, 5'd0, -1, '{5'd0,  3'd2, 1'b0, 1'b1, 1'b0}};
        vt[6] = '{5'd10, 5'd10, 0, 0, 5'd0, -1, '{5'd10, 3'd0, 1'b1, 1'b0, 1'b0}};
        vt[7] = '{5'd18, 5'd18, 1, 0, 5'd0, -1, '{5'd18, 3'd0, 1'b0, 1'b0, 1'b0}};
        vt[8] = '{5'd10, 5'd10, 0, 3, 5'd0, -1, '{5'd10, 3'd0, 1'b1, 1'b0, 1'b0}};

        lnk.trainEnable = 1'b0;
        lnk.rxFinish    = 1'b0; lnk.rxExitTo = 5'd0;
        lnk.txFinish    = 1'b0; lnk.txExitTo = 5'd0;
        lnk.recoveryReq = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_substate", lnk.substate, 0);
        check("rst_strobe",   lnk.substateStrobe, 0);
        check("rst_linkup",   lnk.linkUp, 0);
        check("rst_failed",   lnk.linkFailed, 0);
        check("rst_failcnt",  lnk.failCount, 0);
        reset = 1'b1;
        tick();
        lnk.trainEnable = 1'b1;
        tick();
        check("first_strobe",     lnk.substateStrobe, 1);
        check("first_substate",   lnk.substate, 0);
        tick();
        check("strobe_one_cycle", lnk.substateStrobe, 0);

        // Latency: both finish at T -> substate at T+2, strobe at T+3.
        both_finish(5'd1);
        check("lat_t1_sub",    lnk.substate, 0);
        tick();
        check("lat_t2_sub",    lnk.substate, 1);
        check("lat_t2_strobe", lnk.substateStrobe, 0);
        tick();
        check("lat_t3_strobe", lnk.substateStrobe, 1);

        for (int i = 0; i < 9; i++) apply_vec(vt[i]);

        // L0: watchdog frozen, then recovery beats a same-cycle resolve.
        wait_strobe("l0_strobe");
        tick();
        cnt = 0;
        for (int c = 0; c < 2 * WD + 4; c++) begin
            tick();
            if (lnk.watchdogPulse === 1'b1) cnt++;
        end
        check("l0_no_watchdog", cnt, 0);
        check("l0_linkup",      lnk.linkUp, 1);
        check("l0_substate",    lnk.substate, 10);
        both_finish(5'd10);
        lnk.recoveryReq = 1'b1;
        tick();
        lnk.recoveryReq = 1'b0;
        check("rec_substate", lnk.substate, 11);
        check("rec_linkup",   lnk.linkUp, 0);
        check("rec_mismatch", lnk.mismatchPulse, 0);

        // Watchdog retries into HALT.
        for (int i = 1; i <= MAXR; i++) begin
            if (i > 1) begin
                wait_strobe("retry_walk_strobe");
                tick();
                both_finish(5'd1);
            end
            wait_strobe("retry_strobe");
            tick();
            lnk.rxFinish = 1'b1; lnk.rxExitTo = 5'd1;
            tick();
            lnk.rxFinish = 1'b0;
            n = 1;
            while (lnk.watchdogPulse !== 1'b1 && n < 3 * WD) begin
                tick();
                n++;
            end
            check("wd_pulse", lnk.watchdogPulse, 1);
            if (i == 1) check("wd_latency", n, WD);
            check("wd_failcnt",  lnk.failCount, i);
            check("wd_substate", lnk.substate, 0);
        end
        tick();
        check("halt_failed",   lnk.linkFailed, 1);
        check("halt_substate", lnk.substate, 0);
        check("halt_linkup",   lnk.linkUp, 0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (lnk.substateStrobe === 1'b1) cnt++;
            tick();
        end
        check("halt_no_strobe", cnt, 0);
        check("halt_sticky",    lnk.linkFailed, 1);
        lnk.trainEnable = 1'b0;
        tick();
        check("halt_clear_failed",  lnk.linkFailed, 0);
        check("halt_clear_failcnt", lnk.failCount, 0);

        // Async reset mid-WAIT with rx Done set, then clean restart.
        lnk.trainEnable = 1'b1;
        wait_strobe("ar_strobe0");
        tick();
        both_finish(5'd1);
        wait_strobe("ar_strobe1");
        check("ar_pre_substate", lnk.substate, 1);
        tick();
        lnk.rxFinish = 1'b1; lnk.rxExitTo = 5'd7;
        tick();
        lnk.rxFinish = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("ar_substate", lnk.substate, 0);
        check("ar_strobe",   lnk.substateStrobe, 0);
        check("ar_linkup",   lnk.linkUp, 0);
        check("ar_failed",   lnk.linkFailed, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_strobe("ar_restart_strobe");
        check("ar_restart_sub", lnk.substate, 0);
        tick();
        sb.push_back('{5'd4, 3'd0, 1'b0, 1'b0, 1'b0});
        lnk.txFinish = 1'b1; lnk.txExitTo = 5'd4;
        tick();
        lnk.txFinish = 1'b0;
        tick();
        tick();
        lnk.rxFinish = 1'b1; lnk.rxExitTo = 5'd4;
        tick();
        lnk.rxFinish = 1'b0;
        wait_strobe("ar_final_strobe");
        tick();

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
